// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one imem request at a time, buffers the
// returned instruction for decode, and handles writeback redirects and flushes.
module fetch_ctrl #(
   parameter logic [31:0] reset_vector = 32'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_pc,
   output logic        pc_advance,
   input  logic        redirect_valid,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   output logic [31:0] fetch_count,
   output logic [15:0] flush_count
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

   state_t      state;
   state_t      state_next;
   logic        buf_valid;
   logic [31:0] buf_instr;
   logic [31:0] buf_pc;
   logic [31:0] req_pc;
   logic        load;
   logic        drain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // A response arriving together with a redirect in DRAIN still retires the
   // abandoned request, so the response wins and we move on to REQ.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  state_next = REQ;
         REQ: begin
            if (redirect_valid)                       state_next = REQ;
            else if (imem_req_valid && imem_req_ready) state_next = WAIT;
         end
         WAIT: begin
            if (redirect_valid) state_next = imem_resp_valid ? REQ : DRAIN;
            else if (imem_resp_valid) state_next = REQ;
         end
         DRAIN: begin
            if (imem_resp_valid) state_next = REQ;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request only when the buffer will have room by the time data returns.
   always_comb begin
      imem_req_valid = 1'b0;
      if (state == REQ)
         imem_req_valid = ~redirect_valid & (~buf_valid | (buf_valid & dec_ready));
      pc_advance = imem_req_valid & imem_req_ready;
   end

   assign imem_req_addr = fetch_pc;
   assign dec_valid     = buf_valid;
   assign dec_instr     = buf_instr;
   assign dec_pc        = buf_pc;

   assign load  = (state == WAIT) & imem_resp_valid & ~redirect_valid;
   assign drain = buf_valid & dec_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_valid <= 1'b0;
         buf_instr <= 32'd0;
         buf_pc    <= reset_vector;
      end else if (redirect_valid) begin
         buf_valid <= 1'b0;
      end else if (load) begin
         buf_valid <= 1'b1;
         buf_instr <= imem_resp_data;
         buf_pc    <= req_pc;
      end else if (drain) begin
         buf_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             req_pc <= reset_vector;
      else if (pc_advance) req_pc <= fetch_pc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= 32'd0;
         flush_count <= 16'd0;
      end else begin
         if (load)           fetch_count <= fetch_count + 32'd1;
         if (redirect_valid) flush_count <= flush_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl: a cycle-by-cycle vector table
// followed by a hand-written asynchronous reset sequence.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] fetch_pc = 32'd0;
   logic        pc_advance;
   logic        redirect_valid = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'd0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [31:0] fetch_count;
   logic [15:0] flush_count;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] I0 = 32'h0000_0013;
   localparam logic [31:0] I1 = 32'h0010_0093;
   localparam logic [31:0] I2 = 32'h0020_8113;
   localparam logic [31:0] I3 = 32'h0031_0193;
   localparam logic [31:0] I4 = 32'h0041_8213;
   localparam logic [31:0] I5 = 32'h0052_0293;

   typedef struct {
      logic [31:0] fpc;
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        dr;
      logic        redir;
      logic        e_reqv;
      logic        e_adv;
      logic        e_dv;
      logic        chk_dec;
      logic [31:0] e_dpc;
      logic [31:0] e_instr;
      logic [31:0] e_fc;
      logic [15:0] e_flc;
   } vec_t;

   vec_t vecs[$];

   fetch_ctrl #(.reset_vector(32'd0)) dut (
      .clk(clk),
      .rst(rst),
      .fetch_pc(fetch_pc),
      .pc_advance(pc_advance),
      .redirect_valid(redirect_valid),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data),
      .dec_valid(dec_valid),
      .dec_ready(dec_ready),
      .dec_instr(dec_instr),
      .dec_pc(dec_pc),
      .fetch_count(fetch_count),
      .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic addVec(input logic [31:0] fpc, input logic rdy, input logic rv,
                         input logic [31:0] rd, input logic dr, input logic redir,
                         input logic e_reqv, input logic e_adv, input logic e_dv,
                         input logic chk_dec, input logic [31:0] e_dpc,
                         input logic [31:0] e_instr, input logic [31:0] e_fc,
                         input logic [15:0] e_flc);
      vec_t v;
      v.fpc = fpc;  v.rdy = rdy;  v.rv = rv;  v.rd = rd;  v.dr = dr;  v.redir = redir;
      v.e_reqv = e_reqv;  v.e_adv = e_adv;  v.e_dv = e_dv;  v.chk_dec = chk_dec;
      v.e_dpc = e_dpc;  v.e_instr = e_instr;  v.e_fc = e_fc;  v.e_flc = e_flc;
      vecs.push_back(v);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      fetch_pc        = v.fpc;
      imem_req_ready  = v.rdy;
      imem_resp_valid = v.rv;
      imem_resp_data  = v.rd;
      dec_ready       = v.dr;
      redirect_valid  = v.redir;
   endtask

   task automatic checkVec(input int i, input vec_t v);
      checkOutput($sformatf("v%0d req_valid", i), {31'd0, imem_req_valid}, {31'd0, v.e_reqv});
      checkOutput($sformatf("v%0d pc_advance", i), {31'd0, pc_advance}, {31'd0, v.e_adv});
      checkOutput($sformatf("v%0d req_addr", i), imem_req_addr, v.fpc);
      checkOutput($sformatf("v%0d dec_valid", i), {31'd0, dec_valid}, {31'd0, v.e_dv});
      checkOutput($sformatf("v%0d fetch_count", i), fetch_count, v.e_fc);
      checkOutput($sformatf("v%0d flush_count", i), {16'd0, flush_count}, {16'd0, v.e_flc});
      if (v.chk_dec) begin
         checkOutput($sformatf("v%0d dec_pc", i), dec_pc, v.e_dpc);
         checkOutput($sformatf("v%0d dec_instr", i), dec_instr, v.e_instr);
      end
   endtask

   initial begin
      //     fpc  rdy rv rd          dr rdr  reqv adv dv chk dpc  instr fc flc
      addVec(0,   1, 0, 0,           1, 0,   0, 0, 0, 1, 0,   0,  0, 0);
      addVec(0,   1, 0, 0,           1, 0,   1, 1, 0, 0, 0,   0,  0, 0);
      addVec(4,   1, 1, I0,          1, 0,   0, 0, 0, 0, 0,   0,  0, 0);
      addVec(4,   1, 0, 0,           1, 0,   1, 1, 1, 1, 0,   I0, 1, 0);
      addVec(8,   1, 1, I1,          1, 0,   0, 0, 0, 0, 0,   0,  1, 0);
      addVec(8,   1, 0, 0,           1, 0,   1, 1, 1, 1, 4,   I1, 2, 0);
      addVec(12,  1, 1, I2,          1, 0,   0, 0, 0, 0, 0,   0,  2, 0);
      addVec(12,  0, 0, 0,           1, 0,   1, 0, 1, 1, 8,   I2, 3, 0);
      addVec(12,  1, 0, 0,           1, 0,   1, 1, 0, 0, 0,   0,  3, 0);
      addVec(16,  1, 1, I3,          0, 0,   0, 0, 0, 0, 0,   0,  3, 0);
      addVec(16,  1, 0, 0,           0, 0,   0, 0, 1, 1, 12,  I3, 4, 0);
      addVec(16,  1, 0, 0,           0, 0,   0, 0, 1, 1, 12,  I3, 4, 0);
      addVec(16,  1, 0, 0,           1, 0,   1, 1, 1, 1, 12,  I3, 4, 0);
      addVec(20,  1, 0, 0,           1, 0,   0, 0, 0, 0, 0,   0,  4, 0);
      addVec(20,  1, 0, 0,           1, 1,   0, 0, 0, 0, 0,   0,  4, 0);
      addVec(20,  1, 0, 0,           1, 0,   0, 0, 0, 0, 0,   0,  4, 1);
      addVec(20,  1, 1, 32'hDEADBEEF, 1, 0,  0, 0, 0, 0, 0,   0,  4, 1);
      addVec(100, 1, 0, 0,           1, 0,   1, 1, 0, 1, 12,  I3, 4, 1);
      addVec(104, 1, 1, 32'h0BAD0BAD, 1, 1,  0, 0, 0, 0, 0,   0,  4, 1);
      addVec(200, 1, 0, 0,           1, 0,   1, 1, 0, 1, 12,  I3, 4, 2);
      addVec(204, 1, 1, I4,          1, 0,   0, 0, 0, 0, 0,   0,  4, 2);
      addVec(204, 0, 0, 0,           1, 0,   1, 0, 1, 1, 200, I4, 5, 2);
      for (int k = 0; k < 4; k++)
         addVec(204, 0, 0, 0,        1, 0,   1, 0, 0, 0, 0,   0,  5, 2);
      addVec(204, 1, 0, 0,           1, 0,   1, 1, 0, 0, 0,   0,  5, 2);
      addVec(208, 1, 1, I5,          0, 0,   0, 0, 0, 0, 0,   0,  5, 2);
      addVec(208, 1, 0, 0,           0, 1,   0, 0, 1, 1, 204, I5, 6, 2);
      addVec(300, 1, 0, 0,           0, 0,   1, 1, 0, 0, 0,   0,  6, 3);

      // Hold reset with the memory ready to show nothing is issued meanwhile.
      imem_req_ready = 1'b1;
      fetch_pc       = 32'h0000_0040;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst req_valid", {31'd0, imem_req_valid}, 32'd0);
      checkOutput("rst pc_advance", {31'd0, pc_advance}, 32'd0);
      checkOutput("rst req_addr", imem_req_addr, 32'h0000_0040);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkVec(i, vecs[i]);
         @(negedge clk);
      end

      // The DUT is now in WAIT with a request outstanding; reset asynchronously.
      imem_resp_valid = 1'b0;
      redirect_valid  = 1'b0;
      imem_req_ready  = 1'b1;
      dec_ready       = 1'b0;
      fetch_pc        = 32'h0000_0400;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async dec_valid", {31'd0, dec_valid}, 32'd0);
      checkOutput("async dec_instr", dec_instr, 32'd0);
      checkOutput("async dec_pc", dec_pc, 32'd0);
      checkOutput("async fetch_count", fetch_count, 32'd0);
      checkOutput("async flush_count", {16'd0, flush_count}, 32'd0);
      checkOutput("async req_valid", {31'd0, imem_req_valid}, 32'd0);
      checkOutput("async pc_advance", {31'd0, pc_advance}, 32'd0);
      checkOutput("async req_addr", imem_req_addr, 32'h0000_0400);

      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("post-rst idle req_valid", {31'd0, imem_req_valid}, 32'd0);
      @(negedge clk);
      imem_req_ready = 1'b0;
      #1;
      checkOutput("post-rst req req_valid", {31'd0, imem_req_valid}, 32'd1);
      checkOutput("post-rst req pc_advance", {31'd0, pc_advance}, 32'd0);
      checkOutput("post-rst dec_valid", {31'd0, dec_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
